mod129_seq_ctrl: RTL and testbench

Sequential controller that computes X mod 129 for a 64-bit operand. It time-multiplexes a single 14-bit-chunk folding adder over several cycles instead of a deep combinational fold chain. It sits between an upstream operand producer and a downstream consumer, with valid/ready handshakes on both sides. Latency is fixed by default and can be made data-dependent at compile time.

---
 rtl/mod129_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_mod129_seq_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mod129_seq_ctrl.sv
// mod129_seq_ctrl
//
// Sequential X mod 129 for a 64-bit unsigned operand. A single 14-bit-chunk
// folding adder is reused across several cycles. 2^14 = 1 (mod 129), so each
// fold adds the 14-bit chunks of the accumulator together. Once the value is
// below 2^14, 2^7 = -1 (mod 129) reduces it to 0..128.
//
// Optional feature macro: MOD129_SEQ_EARLY_EXIT_EN
//   undefined : FOLD always runs exactly three cycles, so latency is fixed
//               and fold_count is 3 for every operand.
//   defined   : FOLD goes to FINAL as soon as acc < 2^14. That cycle does no
//               fold, so latency and fold_count depend on the data.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : synchronous, active-high reset
//   in_valid   : operand present on in_x
//   in_x[63:0] : operand X, sampled only on the accept edge
//   in_ready   : high only in IDLE
//   out_valid  : out_r holds a valid result (held until out_ready)
//   out_r[7:0] : X mod 129, range 0..128
//   out_ready  : consumer takes the result (ignored outside DONE)
//   busy       : high exactly when in_ready is low
//   fold_count : folds done for the current/last operand (saturates at 3)

module mod129_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [63:0] in_x,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_r,
    input  logic        out_ready,
    output logic        busy,
    output logic [1:0]  fold_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FOLD  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] acc;
    logic [16:0] fold_sum;
    logic [8:0]  diff;
    logic [7:0]  corr;
    logic [1:0]  fold_next;

    // One fold: sum of the 14-bit chunks. The worst case is 65787, so 17 bits
    // are enough.
    always_comb begin
        fold_sum = {3'b000, acc[13:0]}
                 + {3'b000, acc[27:14]}
                 + {3'b000, acc[41:28]}
                 + {3'b000, acc[55:42]}
                 + {9'd0,   acc[63:56]};
    end

    // Final step. acc[6:0] - acc[13:7] is done in 9 bits, and bit 8 is the
    // sign. A negative difference is brought back into range by adding 129.
    always_comb begin
        diff = {2'b00, acc[6:0]} - {2'b00, acc[13:7]};
        if (diff[8]) begin
            diff = diff + 9'd129;
        end
        corr = diff[7:0];
    end

    always_comb begin
        fold_next = (fold_count == 2'd3) ? 2'd3 : fold_count + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_r      <= '0;
            fold_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc        <= in_x;
                        fold_count <= '0;
                        state      <= FOLD;
                    end
                end
                FOLD: begin
`ifdef MOD129_SEQ_EARLY_EXIT_EN
                    if (acc[63:14] == '0) begin
                        state <= FINAL;
                    end else begin
                        acc        <= {47'd0, fold_sum};
                        fold_count <= fold_next;
                    end
`else
                    // Three folds always reach acc < 2^14. Folding a value
                    // that is already below 2^14 leaves it unchanged.
                    acc        <= {47'd0, fold_sum};
                    fold_count <= fold_next;
                    if (fold_count == 2'd2) begin
                        state <= FINAL;
                    end
`endif
                end
                FINAL: begin
                    out_r     <= corr;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Both are decoded from the state register, so they change only on a
    // clock edge.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mod129_seq_ctrl.sv
// Directed bench for mod129_seq_ctrl in the default fixed-latency build.
// Expected results are computed by hand. The random tail uses X % 129 as the
// reference value.

module tb_mod129_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_x;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_r;
    logic        out_ready;
    logic        busy;
    logic [1:0]  fold_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    mod129_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_r      (out_r),
        .out_ready  (out_ready),
        .busy       (busy),
        .fold_count (fold_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one full transaction. The task is entered at a negedge with the
    // DUT in IDLE. If stall > 0, out_ready stays low for that many cycles
    // after out_valid rises, and a new operand is offered the whole time.
    task automatic do_op(input logic [63:0] x, input logic [7:0] exp,
                         input int unsigned stall, input string tag);
        int unsigned lat;
        logic [7:0]  held;
        check({tag, "_in_ready_idle"}, {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_x      = x;
        out_ready = (stall == 0);
        @(negedge clk);
        // Edge 0 has passed. Changing in_x from here on must have no effect.
        in_valid = 1'b0;
        in_x     = ~x;
        check({tag, "_in_ready_low"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_busy_high"}, {63'd0, busy}, 64'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_out_r"}, {56'd0, out_r}, {56'd0, exp});
        check({tag, "_fold_count"}, {62'd0, fold_count}, 64'd3);
        held = out_r;
        if (stall > 0) begin
            in_valid = 1'b1;
            in_x     = 64'd5;
            for (int i = 0; i < int'(stall); i++) begin
                @(negedge clk);
                check({tag, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
                check({tag, "_stall_r"}, {56'd0, out_r}, {56'd0, held});
                check({tag, "_stall_in_ready"}, {63'd0, in_ready}, 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "_release_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_release_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_release_busy"}, {63'd0, busy}, 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] rx;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_r", {56'd0, out_r}, 64'd0);
        check("rst_fold_count", {62'd0, fold_count}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(64'd204, 8'd75, 0, "x204");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 8'd126, 0, "xmax");
        do_op(64'd128, 8'd128, 0, "x128");
        do_op(64'd129, 8'd0, 0, "x129");
        do_op(64'd0, 8'd0, 0, "x0");
        do_op(64'd16383, 8'd0, 0, "x16383");
        do_op(64'd16384, 8'd1, 0, "x16384");
        do_op(64'd1000, 8'd97, 0, "x1000");
        do_op(64'h8000_0000_0000_0000, 8'd128, 0, "x2p63");
        do_op(64'd204, 8'd75, 10, "bp204");

        // Reset arrives on edge 2 after an accept. The previous result
        // (out_r = 75) must be cleared, and no result may appear afterwards.
        in_valid = 1'b1;
        in_x     = 64'd1000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_r", {56'd0, out_r}, 64'd0);
        check("midrst_fold_count", {62'd0, fold_count}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_result", {63'd0, out_valid}, 64'd0);
        end

        for (int n = 0; n < 200; n++) begin
            rx = {$urandom, $urandom};
            do_op(rx, 8'(rx % 64'd129), $urandom_range(0, 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
